// File: rtl/a0_display_pkg.sv
// Shared constants for the eight-digit seven-segment display driver.
//   DIGIT_OFF / SEG_OFF : active-low "everything off" patterns.
//   GLYPH               : hex digit -> {g,f,e,d,c,b,a}, active-low.
package a0_display_pkg;

  localparam int          DIGITS    = 8;
  localparam logic [7:0]  DIGIT_OFF = 8'hFF;
  localparam logic [7:0]  SEG_OFF   = 8'hFF;

  // Entry 15 is listed first. 10..15 render as A, b, C, d, E, F.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/a0_display_hex7seg.sv
// Combinational hex-to-seven-segment decoder.
//   hex_i : 4-bit nibble
//   seg_o : {g,f,e,d,c,b,a}, active-low
module hex7seg
  import a0_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH[hex_i];

endmodule

// File: rtl/a0_display.sv
// Multiplexed eight-digit hex display driver for the CPU a0 register.
//   clk        : clock, all flops on rising edge
//   rst        : asynchronous active-high reset
//   value      : 32-bit word to show
//   freeze     : 1 keeps the current frame (no new capture)
//   an         : digit enables, active-low, an[i] shows value[4i+3:4i]
//   seg        : {dp,g,f,e,d,c,b,a}, active-low, dp always off
//   frame_done : one-cycle pulse after digit 7 finishes its hold period
module a0_display
  import a0_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   frame_q, frame_d;
  logic          start_q;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          done_q;

  logic          tick;
  logic          wrap;
  logic          blank;
  logic [31:0]   upper;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  hex7seg u_hex7seg (
    .hex_i (nib),
    .seg_o (glyph)
  );

  assign tick  = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap  = tick && (idx_q == 3'd7);
  assign nib   = frame_q[{idx_q, 2'b00} +: 4];
  // Nibbles from the current digit upward; all zero means a leading zero.
  assign upper = frame_q >> {idx_q, 2'b00};
  assign blank = (BLANK_LZ != 0) && (idx_q != 3'd0) && (upper == 32'd0);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    // start_q covers the first frame after reset, when the index is
    // already 0 and no wrap will announce it.
    frame_d = ((start_q || wrap) && !freeze) ? value : frame_q;
    an_d    = DIGIT_OFF;
    seg_d   = SEG_OFF;
    if (!blank) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = {1'b1, glyph};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      frame_q <= 32'd0;
      start_q <= 1'b1;
      an_q    <= DIGIT_OFF;
      seg_q   <= SEG_OFF;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      start_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
      done_q  <= wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_a0_display.sv
module tb_a0_display;

  localparam int S  = 4;
  localparam int FR = 8 * S;

  localparam logic [7:0] GL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] value = 32'd0;
  logic [7:0]  an1, seg1, an0, seg0;
  logic        fd1, fd0;

  a0_display #(.SCAN_DIV(S), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze),
    .an(an1), .seg(seg1), .frame_done(fd1));

  a0_display #(.SCAN_DIV(S), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze),
    .an(an0), .seg(seg0), .frame_done(fd0));

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          k    = 0;      // rising edges since reset release
  logic [31:0] frame_m = 32'd0;

  typedef struct {
    logic [31:0] v;
    int          d;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;

  task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
    end
  endtask

  // Expected display of digit d for a captured word f.
  function automatic void disp(input logic [31:0] f, input int d, input bit blz,
                               output logic [7:0] a, output logic [7:0] s);
    logic [31:0] hi;
    hi = f >> (4 * d);
    a  = 8'hFF;
    s  = 8'hFF;
    if (!(blz && d > 0 && hi == 32'd0)) begin
      a[d] = 1'b0;
      s    = GL[hi[3:0]];
    end
  endfunction

  // One clock with reference-model update and full output check.
  task automatic step();
    logic [31:0] v, pf;
    bit          frz;
    int          d;
    logic [7:0]  ea, es;
    v   = value;
    frz = freeze;
    pf  = frame_m;
    @(posedge clk);
    k++;
    if ((k == 1 || k % FR == 0) && !frz) frame_m = v;
    #1;
    d = ((k - 1) / S) % 8;
    disp(pf, d, 1'b1, ea, es);
    cmp8("an_blz1", an1, ea);
    cmp8("seg_blz1", seg1, es);
    disp(pf, d, 1'b0, ea, es);
    cmp8("an_blz0", an0, ea);
    cmp8("seg_blz0", seg0, es);
    cmp8("done_blz1", {7'd0, fd1}, {7'd0, (k % FR == 0)});
    cmp8("done_blz0", {7'd0, fd0}, {7'd0, (k % FR == 0)});
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    cmp8("rst_an1", an1, 8'hFF);
    cmp8("rst_seg1", seg1, 8'hFF);
    cmp8("rst_an0", an0, 8'hFF);
    cmp8("rst_seg0", seg0, 8'hFF);
    cmp8("rst_done", {6'd0, fd1, fd0}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    k       = 0;
    frame_m = 32'd0;
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h1234ABCD, 0, 8'hFE, 8'hA1};
    tbl[1] = '{32'h1234ABCD, 1, 8'hFD, 8'hC6};
    tbl[2] = '{32'h1234ABCD, 2, 8'hFB, 8'h83};
    tbl[3] = '{32'h1234ABCD, 3, 8'hF7, 8'h88};
    tbl[4] = '{32'h1234ABCD, 7, 8'h7F, 8'hF9};
    tbl[5] = '{32'h00000050, 0, 8'hFE, 8'hC0};
    tbl[6] = '{32'h00000050, 1, 8'hFD, 8'h92};
    tbl[7] = '{32'h00000050, 2, 8'hFF, 8'hFF};
    tbl[8] = '{32'h00000050, 7, 8'hFF, 8'hFF};
    tbl[9] = '{32'h00000000, 1, 8'hFF, 8'hFF};

    #2;
    // Static vectors, each from a fresh reset.
    for (int i = 0; i < 10; i++) begin
      value  = tbl[i].v;
      freeze = 1'b0;
      do_reset();
      for (int c = 0; c < tbl[i].d * S + 2; c++) step();
      cmp8("tbl_an", an1, tbl[i].an);
      cmp8("tbl_seg", seg1, tbl[i].seg);
    end

    // Full frame of 1234ABCD: frame_done cadence checked by the model.
    value = 32'h1234ABCD;
    do_reset();
    while (k < 2 * FR + 2) step();

    // Freeze holds FFFFFFFF across three frames of value=0.
    value = 32'hFFFFFFFF;
    do_reset();
    step();
    step();
    freeze = 1'b1;
    value  = 32'd0;
    while (k < 3 * FR + 5) step();
    cmp8("frz_an", an1, 8'hFD);
    cmp8("frz_seg", seg1, 8'h8E);
    freeze = 1'b0;
    while (k < 4 * FR + 2) step();
    cmp8("unfrz_an", an1, 8'hFE);
    cmp8("unfrz_seg", seg1, 8'hC0);

    // Value changes while digit 3 is shown.
    value = 32'h11111111;
    do_reset();
    while (k < FR + 3 * S + 1) step();
    value = 32'h22222222;
    while (k < FR + 7 * S + 1) step();
    cmp8("mid_an", an1, 8'h7F);
    cmp8("mid_seg", seg1, 8'hF9);
    while (k < 2 * FR + 2) step();
    cmp8("next_an", an1, 8'hFE);
    cmp8("next_seg", seg1, 8'hA4);

    // Reset at digit 5, then a full frame with frame_done quiet until its end.
    value = 32'h89ABCDEF;
    do_reset();
    while (k < 5 * S + 2) step();
    do_reset();
    while (k < FR + 3) step();

    // Randomized run against the model, biased toward leading zeros.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) value = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
